parity_tx_ctrl: RTL and testbench
=================================

PARITY_TX_CTRL -- requirements
Module: parity_tx_ctrl

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 4, meaning clock cycles per serial bit period (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1, meaning input_word and parity_control are valid.
REQ-005 The block SHALL have port input_word, input, 8, the data byte to transmit.
REQ-006 The block SHALL have port parity_control, input, 1, where 0 selects even parity and 1 selects odd parity.
REQ-007 The block SHALL have port in_ready, output, 1, meaning the block accepts a word this cycle.
REQ-008 The block SHALL have port serial_out, output, 1, the serial line, which idles high.
REQ-009 The block SHALL have port output_word, output, 9, the latched encoded word {parity, data[7:0]}.
REQ-010 The block SHALL have port busy, output, 1, high whenever a frame is in progress.
REQ-011 The block SHALL have port frame_done, output, 1, a one-cycle pulse at the end of a frame.

Function
REQ-012 A handshake SHALL occur on a rising clk edge where in_valid=1 and in_ready=1.
- At handshake, input_word and parity_control are latched together.
- output_word is loaded as {parity_bit, input_word}.
REQ-013 The parity bit SHALL make the total count of 1s in output_word even when parity_control=0, and odd when it is 1.
REQ-014 The FSM SHALL have five states: IDLE, START, DATA, PARITY, STOP.
- IDLE: in_ready=1, busy=0, serial_out=1.
- A handshake in IDLE moves the FSM to START on the next cycle.
- All other states: in_ready=0, busy=1.
REQ-015 Each non-IDLE state bit SHALL be held on serial_out for exactly CLKS_PER_BIT cycles, timed by a bit-period counter.
- START drives 0.
- DATA drives data bits 0..7, LSB first, using a 3-bit index; the FSM leaves DATA after index 7 completes.
- PARITY drives output_word[8].
- STOP drives 1.
REQ-016 A frame SHALL last exactly 11*CLKS_PER_BIT cycles, from the first START cycle to the last STOP cycle inclusive.
REQ-017 frame_done SHALL be 1 only during the last STOP cycle, and the FSM SHALL be in IDLE with in_ready=1 on the following cycle.
REQ-018 in_valid SHALL be ignored while in_ready=0: there is no buffering, and the source holds in_valid until accepted.
REQ-019 Changes on input_word or parity_control after the handshake SHALL NOT affect the frame in progress.
REQ-020 serial_out SHALL be driven from a flop with no combinational path from any input.
REQ-021 Back-to-back frames SHALL be separated by exactly one IDLE cycle when in_valid is held high.
REQ-022 With CLKS_PER_BIT=1, the block SHALL produce one bit per cycle and an 11-cycle frame.

Reset
REQ-023 Asserting reset SHALL immediately force the following, in any state including mid-frame:
- state=IDLE, serial_out=1, in_ready=0, busy=0, frame_done=0, output_word=9'h000;
- bit-period counter and data index cleared.
REQ-024 in_ready SHALL rise on the first clk edge after reset deasserts; a partial frame SHALL NOT resume.

Structure
REQ-025 The following SHALL live in a shared package/include (parity_tx_defs):
- state encodings;
- FRAME_BITS=11;
- START_BIT=0 and STOP_BIT=1 constants.
REQ-026 Parity encoding SHALL be a combinational sub-module, parity_encoder, instantiated once.
- Ports: parity_control, input_word[7:0], output_word[8:0].
- Its output is registered into output_word at handshake.

Verification
REQ-027 Bench SHALL cover each of the following scenarios, with CLKS_PER_BIT=4 unless stated:
- Even parity: input_word=8'h34, parity_control=0, handshake → output_word=9'h134; serial_out = 0, 0,0,1,0,1,1,0,0, 1, 1, each bit held 4 cycles; frame_done pulses in cycle 44.
- Odd parity: input_word=8'h34, parity_control=1 → output_word=9'h034; parity bit slot = 0.
- Parity sweep: input_word[0] toggled across {0,1} × parity_control {0,1} using 8'h34/8'h35 → parity bits 1,0,0,1 respectively.
- Back-to-back: in_valid held high with 8'hFF then 8'h00 (even) → frames separated by one IDLE cycle; parity bits 0 then 0; in_ready low for 44 cycles per frame.
- Reset mid-frame: assert reset in DATA bit 3 → serial_out=1 and busy=0 immediately; next frame 8'h01 (odd) transmits correctly with parity bit 0.
- CLKS_PER_BIT=1: input_word=8'hA5, even parity → 11-cycle frame, parity bit 0, frame_done in cycle 11.

Source files
------------

// File: rtl/parity_tx_ctrl_pkg.sv
// parity_tx_defs: shared definitions for the parity serial transmitter.
//   tx_state_e  - FSM state encodings
//   tx_req_t    - latched request (data byte + parity select)
//   FRAME_BITS  - serial bits per frame (start + 8 data + parity + stop)
//   START_BIT / STOP_BIT - line levels for the framing bits
//   parity_bit() - parity bit that makes {p, data} even (odd=0) or odd (odd=1)
package parity_tx_defs;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  typedef struct packed {
    logic       odd;
    logic [7:0] data;
  } tx_req_t;

  localparam int   FRAME_BITS = 11;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;

  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/parity_encoder.sv
// parity_encoder: combinational {parity, data} encoder.
//   parity_control - 0 even, 1 odd total count of ones in output_word
//   input_word     - data byte
//   output_word    - {parity, input_word}
module parity_encoder
  import parity_tx_defs::*;
(
  input  logic       parity_control,
  input  logic [7:0] input_word,
  output logic [8:0] output_word
);

  assign output_word = {parity_bit(input_word, parity_control), input_word};

endmodule

// File: rtl/parity_tx_ctrl.sv
// parity_tx_ctrl: valid/ready byte input, serial frame output
// (start, 8 data LSB first, parity, stop), each bit CLKS_PER_BIT cycles.
//   clk, reset     - rising-edge clock, async active-high reset
//   in_valid       - input_word/parity_control valid
//   input_word     - byte to send
//   parity_control - 0 even, 1 odd
//   in_ready       - accepting a word this cycle (only in IDLE)
//   serial_out     - serial line, idles high, registered
//   output_word    - latched {parity, data}
//   busy           - frame in progress
//   frame_done     - pulse during the last STOP cycle
module parity_tx_ctrl
  import parity_tx_defs::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] input_word,
  input  logic       parity_control,
  output logic       in_ready,
  output logic       serial_out,
  output logic [8:0] output_word,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [7:0] CNT_MAX = 8'(CLKS_PER_BIT - 1);

  tx_state_e  state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [2:0] idx, idx_nxt;
  logic [8:0] word_q, word_nxt;
  logic [8:0] enc_word;
  logic       serial_nxt, rdy_nxt, busy_nxt, done_nxt;
  logic       hs;
  tx_req_t    req;

  assign req = '{odd: parity_control, data: input_word};

  parity_encoder u_enc (
    .parity_control (req.odd),
    .input_word     (req.data),
    .output_word    (enc_word)
  );

  // in_ready is a flop, so the handshake never sees a combinational
  // in_valid -> in_ready loop.
  assign hs = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    word_nxt  = word_q;
    case (state)
      IDLE: begin
        if (hs) begin
          state_nxt = START;
          cnt_nxt   = '0;
          idx_nxt   = '0;
          word_nxt  = enc_word;
        end
      end
      START, DATA, PARITY, STOP: begin
        if (cnt == CNT_MAX) begin
          cnt_nxt = '0;
          case (state)
            START:   begin state_nxt = DATA; idx_nxt = '0; end
            DATA:    begin
              if (idx == 3'd7) state_nxt = PARITY;
              else             idx_nxt   = idx + 3'd1;
            end
            PARITY:  state_nxt = STOP;
            default: state_nxt = IDLE;
          endcase
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next-state view so serial_out is a
  // pure flop and the framing lines up with the state register.
  always_comb begin
    serial_nxt = STOP_BIT;
    case (state_nxt)
      START:   serial_nxt = START_BIT;
      DATA:    serial_nxt = word_nxt[idx_nxt];
      PARITY:  serial_nxt = word_nxt[8];
      STOP:    serial_nxt = STOP_BIT;
      default: serial_nxt = STOP_BIT;
    endcase
    rdy_nxt  = (state_nxt == IDLE);
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == STOP) && (cnt_nxt == CNT_MAX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      word_q     <= '0;
      serial_out <= 1'b1;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      word_q     <= word_nxt;
      serial_out <= serial_nxt;
      in_ready   <= rdy_nxt;
      busy       <= busy_nxt;
      frame_done <= done_nxt;
    end
  end

  assign output_word = word_q;

endmodule

// File: tb/tb_parity_tx_ctrl.sv
module tb_parity_tx_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] input_word;
  logic       parity_control;
  logic       use1;

  logic       in_ready4, serial4, busy4, done4;
  logic [8:0] ow4;
  logic       in_ready1, serial1, busy1, done1;
  logic [8:0] ow1;

  logic       m_ready, m_serial, m_busy, m_done;
  logic [8:0] m_ow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  parity_tx_ctrl #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid && !use1),
    .input_word(input_word), .parity_control(parity_control),
    .in_ready(in_ready4), .serial_out(serial4), .output_word(ow4),
    .busy(busy4), .frame_done(done4)
  );

  parity_tx_ctrl #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid && use1),
    .input_word(input_word), .parity_control(parity_control),
    .in_ready(in_ready1), .serial_out(serial1), .output_word(ow1),
    .busy(busy1), .frame_done(done1)
  );

  assign m_ready  = use1 ? in_ready1 : in_ready4;
  assign m_serial = use1 ? serial1   : serial4;
  assign m_busy   = use1 ? busy1     : busy4;
  assign m_done   = use1 ? done1     : done4;
  assign m_ow     = use1 ? ow1       : ow4;

  typedef struct {
    logic [7:0] word;
    logic       pc;
    logic [8:0] exp_ow;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (m_ready !== 1'b1 && n < 200) begin tick(); n++; end
    chk({name, "_ready_timeout"}, 32'(m_ready === 1'b1), 32'd1);
  endtask

  // Called at cycle 1 of a frame (just after the handshake edge). Leaves the
  // bench in the idle cycle that follows the last STOP cycle.
  task automatic check_frame(input string name, input logic [8:0] exp_ow, input int cpb);
    int  nc;
    int  b;
    logic expb;
    nc = 11 * cpb;
    chk({name, "_output_word"}, 32'(m_ow), 32'(exp_ow));
    for (int c = 1; c <= nc; c++) begin
      b = (c - 1) / cpb;
      if (b == 0)       expb = 1'b0;
      else if (b <= 8)  expb = exp_ow[b-1];
      else if (b == 9)  expb = exp_ow[8];
      else              expb = 1'b1;
      chk($sformatf("%s_serial_c%0d", name, c), 32'(m_serial), 32'(expb));
      chk($sformatf("%s_done_c%0d", name, c), 32'(m_done), 32'(c == nc));
      chk($sformatf("%s_busy_c%0d", name, c), 32'(m_busy), 32'd1);
      chk($sformatf("%s_ready_c%0d", name, c), 32'(m_ready), 32'd0);
      tick();
    end
    chk({name, "_idle_ready"},  32'(m_ready),  32'd1);
    chk({name, "_idle_busy"},   32'(m_busy),   32'd0);
    chk({name, "_idle_serial"}, 32'(m_serial), 32'd1);
    chk({name, "_idle_done"},   32'(m_done),   32'd0);
    chk({name, "_held_word"},   32'(m_ow),     32'(exp_ow));
  endtask

  task automatic run_frame(input string name, input logic [7:0] w, input logic pc,
                           input logic [8:0] exp_ow, input int cpb);
    wait_ready(name);
    in_valid = 1'b1; input_word = w; parity_control = pc;
    tick();
    // Scramble inputs after acceptance; the frame must not change.
    in_valid = 1'b0; input_word = ~w; parity_control = ~pc;
    check_frame(name, exp_ow, cpb);
  endtask

  initial begin
    vecs[0] = '{8'h34, 1'b0, 9'h134};
    vecs[1] = '{8'h34, 1'b1, 9'h034};
    vecs[2] = '{8'h35, 1'b0, 9'h035};
    vecs[3] = '{8'h35, 1'b1, 9'h135};
    vecs[4] = '{8'hFF, 1'b0, 9'h0FF};
    vecs[5] = '{8'h00, 1'b1, 9'h100};
    vecs[6] = '{8'hA5, 1'b1, 9'h1A5};

    use1 = 1'b0; in_valid = 1'b0; input_word = 8'h00; parity_control = 1'b0;
    reset = 1'b1;
    #12;
    chk("rst_ready",  32'(in_ready4), 32'd0);
    chk("rst_serial", 32'(serial4),   32'd1);
    chk("rst_busy",   32'(busy4),     32'd0);
    chk("rst_done",   32'(done4),     32'd0);
    chk("rst_word",   32'(ow4),       32'h000);
    #10 reset = 1'b0;
    tick();
    chk("rst_rel_ready", 32'(in_ready4), 32'd1);

    for (int i = 0; i < 7; i++)
      run_frame($sformatf("vec%0d", i), vecs[i].word, vecs[i].pc, vecs[i].exp_ow, 4);

    // Back-to-back with in_valid held: exactly one IDLE cycle between frames.
    wait_ready("b2b");
    in_valid = 1'b1; input_word = 8'hFF; parity_control = 1'b0;
    tick();
    input_word = 8'h00;
    check_frame("b2b_a", 9'h0FF, 4);
    tick();
    in_valid = 1'b0;
    check_frame("b2b_b", 9'h000, 4);

    // Reset during DATA bit 3 (cycles 17..20 of the frame).
    wait_ready("mid");
    in_valid = 1'b1; input_word = 8'h34; parity_control = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c < 18; c++) tick();
    chk("mid_pre_busy", 32'(busy4), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_serial", 32'(serial4),   32'd1);
    chk("mid_rst_busy",   32'(busy4),     32'd0);
    chk("mid_rst_ready",  32'(in_ready4), 32'd0);
    chk("mid_rst_done",   32'(done4),     32'd0);
    chk("mid_rst_word",   32'(ow4),       32'h000);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("mid_rel_ready", 32'(in_ready4), 32'd1);
    chk("mid_rel_busy",  32'(busy4),     32'd0);
    run_frame("after_rst", 8'h01, 1'b1, 9'h001, 4);

    // One bit per cycle.
    use1 = 1'b1;
    #1;
    run_frame("cpb1", 8'hA5, 1'b0, 9'h0A5, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
